fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address of the first instruction fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, the instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, the instruction-memory read address.
REQ-006 SHALL have port imem_ack, input, 1; when high, imem_rdata is valid for the current request.
REQ-007 SHALL have port imem_rdata, input, 32, the instruction word from memory.
REQ-008 SHALL have port instr, output, 32, the held instruction for the decode/control stage.
REQ-009 SHALL have port pc, output, 32, the address of the held instr.
REQ-010 SHALL have port instr_valid, output, 1; when high, instr and pc are valid.
REQ-011 SHALL have port instr_ready, input, 1, pulsed by the downstream stage when the held instruction completes.
REQ-012 SHALL have port pcsrc, input, 1, the branch/jump-taken signal from the control stage.
REQ-013 SHALL have port immext, input, 32, the sign-extended branch/jump offset.
REQ-014 SHALL have port fault, output, 1, the sticky misaligned-target flag.
REQ-015 SHALL have port retired, output, 32, the count of completed instructions.

Function
REQ-016 SHALL implement states FETCH, HOLD and FAULT, encoded in a registered state variable.
REQ-017 FETCH SHALL behave as follows: imem_req=1, imem_addr=fetch_pc, instr_valid=0.
- imem_ack=1 SHALL capture imem_rdata into instr and fetch_pc into pc, and move to HOLD next edge.
- imem_ack may be high in the same cycle imem_req first rises.
REQ-018 With imem_ack=0 in FETCH, the block SHALL remain in FETCH, holding imem_req and imem_addr stable.
REQ-019 HOLD SHALL behave as follows: imem_req=0, instr_valid=1, and instr and pc stable until instr_ready=1.
REQ-020 On instr_ready=1 in HOLD, the block SHALL compute next = pcsrc ? pc+immext : pc+4, using 32-bit modulo add with wrap-around and no overflow flag.
REQ-021 If next[1:0]==0, the block SHALL load fetch_pc=next, increment retired, and go to FETCH.
REQ-022 If next[1:0]!=0, the block SHALL set fault=1, leave fetch_pc unchanged, increment retired, and go to FAULT.
REQ-023 pcsrc and immext SHALL be sampled only in HOLD with instr_ready=1, and ignored otherwise.
REQ-024 imem_ack SHALL be ignored in HOLD and FAULT, and imem_rdata SHALL be ignored whenever imem_ack=0.
REQ-025 instr_ready SHALL be ignored in FETCH and FAULT.
REQ-026 FAULT SHALL behave as follows: imem_req=0, instr_valid=0, fault=1, and the state is held until rst.
REQ-027 Throughput SHALL be at most one instruction per 2 cycles: ack at edge N gives instr_valid at N+1, and ready at N+1 gives imem_req again at N+2.
REQ-028 retired SHALL be a 32-bit counter that wraps from 32'hFFFF_FFFF to 0.
REQ-029 All outputs SHALL be registered or decoded from state only, with no combinational path from imem_ack, instr_ready, pcsrc or immext to any output.

Reset
REQ-030 rst=1 SHALL asynchronously force the following values:
- state=FETCH and fetch_pc=RESET_PC;
- pc=RESET_PC and instr=32'h0000_0013 (nop);
- instr_valid=0, fault=0 and retired=0.
REQ-031 While rst=1, imem_req SHALL be 0, and the block SHALL begin requesting on the first rising clk edge after rst falls.
REQ-032 Reset asserted in any state, including mid-request with imem_ack pending, SHALL abandon the request, and any ack arriving in the same cycle as reset SHALL be discarded.

Verification
REQ-033 Sequential fetch: RESET_PC=0, zero-latency ack with rdata=addr, ready pulsed each HOLD.
- Required: pc sequence 0,4,8,C.
- Required: retired=3 after the 3rd ready.
- Required: instr equals pc each HOLD.
REQ-034 Stalled memory: ack delayed 3 cycles.
- Required: imem_req and imem_addr stable for 4 cycles.
- Required: instr_valid=0 throughout, then 1 on the cycle after ack.
REQ-035 Taken branch: pc=0x100, pcsrc=1, immext=0xFFFF_FFF0, ready=1.
- Required: next imem_addr=0xF0.
- Required: pcsrc=1 in FETCH has no effect.
REQ-036 Misaligned jump: pc=0x20, pcsrc=1, immext=0x6, ready=1.
- Required: fault=1, state FAULT, imem_req=0 thereafter.
- Required: retired incremented.
REQ-037 Wrap and reset: pc=0xFFFF_FFFC with pcsrc=0 gives imem_addr=0.
- Required: rst pulsed mid-FETCH gives immediate instr_valid=0 and instr=0x13.
- Required: fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time, holds it for decode,
// and steps the PC by 4 or by the branch offset when the held instruction retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcsrc,
    input  logic [31:0] immext,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;

    assign next_pc   = pcsrc ? (pc + immext) : (pc + 32'd4);
    assign imem_addr = fetch_pc;

    // imem_req is a register so it stays low during reset and rises on the
    // first edge after reset; an ack only counts once the request is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            instr       <= 32'h0000_0013;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            retired     <= '0;
            imem_req    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr       <= imem_rdata;
                        pc          <= fetch_pc;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        imem_req    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] == 2'b00) begin
                            fetch_pc <= next_pc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            fault    <= 1'b1;
                            state    <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                    state       <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and held
// instructions are queued by a PC model and checked as the DUT produces them.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pcsrc;
    logic [31:0] immext;
    logic        fault;
    logic [31:0] retired;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pcsrc       (pcsrc),
        .immext      (immext),
        .fault       (fault),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_instr;
    logic [31:0] exp_ret;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b1;
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        if (imem_req !== 1'b1) begin
            chk("req_timeout", {31'd0, imem_req}, 32'd1);
            ok = 1'b0;
        end
    endtask

    // Serve one fetch after lat stall cycles, then check the held word.
    task automatic do_fetch(input int lat, input logic [31:0] data);
        bit          ok;
        logic [31:0] a;
        wait_req(ok);
        if (!ok) return;
        a = exp_addr_q.pop_front();
        chk("imem_addr", imem_addr, a);
        exp_pc_q.push_back(a);
        exp_instr_q.push_back(data);
        model_pc    = a;
        model_instr = data;
        for (int i = 0; i < lat; i++) begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'b1;
            pcsrc       = 1'b1;
            immext      = $urandom;
            tick();
            chk("stall_req",   {31'd0, imem_req},    32'd1);
            chk("stall_addr",  imem_addr,            a);
            chk("stall_valid", {31'd0, instr_valid}, 32'd0);
        end
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = data;
        tick();
        imem_ack    = 1'b0;
        imem_rdata  = $urandom;
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        chk("req_after_ack",   {31'd0, imem_req},    32'd0);
        chk("hold_pc",    pc,    exp_pc_q.pop_front());
        chk("hold_instr", instr, exp_instr_q.pop_front());
    endtask

    // Keep the instruction held for idle cycles, then retire it.
    task automatic do_retire(input logic pcs, input logic [31:0] imm, input int idle);
        logic [31:0] nxt;
        for (int i = 0; i < idle; i++) begin
            instr_ready = 1'b0;
            pcsrc       = 1'($urandom);
            immext      = $urandom;
            imem_ack    = 1'b1;
            imem_rdata  = $urandom;
            tick();
            chk("hold_valid",        {31'd0, instr_valid}, 32'd1);
            chk("hold_pc_stable",    pc,                   model_pc);
            chk("hold_instr_stable", instr,                model_instr);
            chk("hold_req",          {31'd0, imem_req},    32'd0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        pcsrc       = pcs;
        immext      = imm;
        tick();
        instr_ready = 1'b0;
        pcsrc       = 1'($urandom);
        immext      = $urandom;
        nxt     = pcs ? model_pc + imm : model_pc + 32'd4;
        exp_ret = exp_ret + 32'd1;
        chk("retired",           retired,              exp_ret);
        chk("valid_after_ready", {31'd0, instr_valid}, 32'd0);
        if (nxt[1:0] == 2'b00) begin
            exp_addr_q.push_back(nxt);
            chk("req_after_ready", {31'd0, imem_req}, 32'd1);
            chk("fault_clear",     {31'd0, fault},    32'd0);
        end else begin
            chk("fault_set", {31'd0, fault}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                imem_ack    = 1'b1;
                instr_ready = 1'b1;
                tick();
                chk("fault_hold",    {31'd0, fault},       32'd1);
                chk("fault_req",     {31'd0, imem_req},    32'd0);
                chk("fault_valid",   {31'd0, instr_valid}, 32'd0);
                chk("fault_retired", retired,              exp_ret);
            end
            imem_ack    = 1'b0;
            instr_ready = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        immext      = '0;
        exp_ret     = '0;
        model_pc    = RST_PC;
        model_instr = 32'h0000_0013;
        tick();
        tick();
        chk("rst_req",     {31'd0, imem_req},    32'd0);
        chk("rst_instr",   instr,                32'h0000_0013);
        chk("rst_pc",      pc,                   RST_PC);
        chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
        chk("rst_fault",   {31'd0, fault},       32'd0);
        chk("rst_retired", retired,              32'd0);
        rst = 1'b0;
        exp_addr_q.push_back(RST_PC);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);

        // Sequential fetch, instruction word equals its address
        for (int i = 0; i < 3; i++) begin
            do_fetch(0, exp_addr_q[0]);
            do_retire(1'b0, 32'd0, i);
        end
        chk("retired_after_3", retired, 32'd3);
        do_fetch(0, exp_addr_q[0]);
        do_retire(1'b0, 32'd0, 1);

        // Stalled memory, then branches
        do_fetch(3, 32'hDEAD_BEEF);
        do_retire(1'b1, 32'h0000_00F0, 0);
        do_fetch(2, 32'h0000_0113);
        do_retire(1'b1, 32'hFFFF_FFF0, 1);
        chk("branch_addr", imem_addr, 32'h0000_00F0);
        do_fetch(1, 32'h1234_5678);
        do_retire(1'b1, 32'hFFFF_FF0C, 0);
        chk("pre_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(0, 32'hCAFE_F00D);
        do_retire(1'b0, 32'd0, 0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        do_fetch(0, 32'h0000_0033);
        do_retire(1'b0, 32'd0, 0);

        // Reset asserted mid-request with an ack pending
        wait_req(ok);
        chk("pre_rst_addr", imem_addr, exp_addr_q.pop_front());
        tick();
        #2;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("async_rst_valid",   {31'd0, instr_valid}, 32'd0);
        chk("async_rst_instr",   instr,                32'h0000_0013);
        chk("async_rst_pc",      pc,                   RST_PC);
        chk("async_rst_req",     {31'd0, imem_req},    32'd0);
        chk("async_rst_retired", retired,              32'd0);
        tick();
        chk("rst_ack_discard", instr,                32'h0000_0013);
        chk("rst_ack_valid",   {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b0;
        rst      = 1'b0;
        exp_ret  = '0;
        exp_addr_q.delete();
        exp_addr_q.push_back(RST_PC);
        do_fetch(0, 32'h0000_0093);

        // Misaligned jump from 0x20
        do_retire(1'b1, 32'h0000_0020, 0);
        do_fetch(1, 32'h0000_006F);
        do_retire(1'b1, 32'h0000_0006, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
